// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronises and edge-detects up to eight sources and
// sequences one fixed-priority request at a time through request, vector-read acknowledge and EOI.
module irq_ctrl #(
    parameter int          N_SRC     = 8,
    parameter logic [7:0]  BASE_ADDR = 8'h10
) (
    input  logic             clk_ip,
    input  logic             reset_ip,
    input  logic [N_SRC-1:0] src_ip,
    input  logic [7:0]       addr_ip,
    input  logic [7:0]       data_ip,
    input  logic             wr_en_ip,
    input  logic             rd_en_ip,
    output logic [7:0]       data_op,
    output logic             sel_op,
    output logic             irq_op
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] OFF_IE   = 3'd0;
    localparam logic [2:0] OFF_IP   = 3'd1;
    localparam logic [2:0] OFF_VEC  = 3'd2;
    localparam logic [2:0] OFF_CTRL = 3'd3;
    localparam logic [2:0] OFF_EOI  = 3'd4;

    state_t           state_reg, state_next;
    logic [N_SRC-1:0] s1_reg, s2_reg, s3_reg;
    logic [N_SRC-1:0] ie_reg, ip_reg, ip_next;
    logic             gie_reg;
    logic             irq_reg;

    logic [8:0]       off_wide;
    logic [2:0]       off;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] clr_mask, ack_mask;
    logic [2:0]       idx;
    logic             req, ack, eoi;
    logic             wr_ie, wr_ip, wr_ctrl;
    logic [7:0]       ie_pad, ip_pad, vec;

    // Addresses below BASE_ADDR wrap into bit 8, so a single upper-bound compare decodes the window.
    assign off_wide = {1'b0, addr_ip} - {1'b0, BASE_ADDR};
    assign sel_op   = (off_wide <= 9'd4);
    assign off      = off_wide[2:0];

    assign wr_ie   = wr_en_ip && sel_op && (off == OFF_IE);
    assign wr_ip   = wr_en_ip && sel_op && (off == OFF_IP);
    assign wr_ctrl = wr_en_ip && sel_op && (off == OFF_CTRL);
    assign eoi     = wr_en_ip && sel_op && (off == OFF_EOI);

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign edge_det[gi] = s2_reg[gi] & ~s3_reg[gi];
            assign clr_mask[gi] = wr_ip & data_ip[gi];
            assign ack_mask[gi] = ack && (idx == 3'(gi));
        end
    endgenerate

    assign pend = ip_reg & ie_reg;

    // Highest index first so the lowest set bit wins.
    always_comb begin
        idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign req = (|pend) & gie_reg;
    assign ack = (state_reg == REQ) && rd_en_ip && sel_op && (off == OFF_VEC) && req;
    assign vec = req ? {1'b1, 4'b0000, idx} : 8'h00;

    // A new edge wins over both software clear and acknowledge clear.
    assign ip_next = (ip_reg & ~clr_mask & ~ack_mask) | edge_det;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_next = ACTIVE;
                end else if (!req) begin
                    state_next = IDLE;
                end
            end
            ACTIVE: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_ip or posedge reset_ip) begin
        if (reset_ip) begin
            s1_reg    <= '0;
            s2_reg    <= '0;
            s3_reg    <= '0;
            ie_reg    <= '0;
            ip_reg    <= '0;
            gie_reg   <= 1'b0;
            state_reg <= IDLE;
            irq_reg   <= 1'b0;
        end else begin
            s1_reg    <= src_ip;
            s2_reg    <= s1_reg;
            s3_reg    <= s2_reg;
            ip_reg    <= ip_next;
            state_reg <= state_next;
            irq_reg   <= (state_next == REQ);
            if (wr_ie) begin
                ie_reg <= data_ip[N_SRC-1:0];
            end
            if (wr_ctrl) begin
                gie_reg <= data_ip[0];
            end
        end
    end

    assign irq_op = irq_reg;

    always_comb begin
        ie_pad = 8'h00;
        ip_pad = 8'h00;
        ie_pad[N_SRC-1:0] = ie_reg;
        ip_pad[N_SRC-1:0] = ip_reg;
    end

    always_comb begin
        data_op = 8'h00;
        if (sel_op) begin
            case (off)
                OFF_IE:   data_op = ie_pad;
                OFF_IP:   data_op = ip_pad;
                OFF_VEC:  data_op = vec;
                OFF_CTRL: data_op = {6'b000000, (state_reg == ACTIVE), gie_reg};
                default:  data_op = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a register-access vector table followed by hand-written
// multi-cycle sequences for latency, priority, masking, collision, level sources and reset.
`timescale 1ns/100ps
module tb_irq_ctrl;

    logic       clk_ip   = 1'b0;
    logic       reset_ip = 1'b1;
    logic [7:0] src_ip   = 8'h00;
    logic [7:0] addr_ip  = 8'h00;
    logic [7:0] data_ip  = 8'h00;
    logic       wr_en_ip = 1'b0;
    logic       rd_en_ip = 1'b0;
    logic [7:0] data_op;
    logic       sel_op;
    logic       irq_op;

    int n_vec = 0;
    int n_err = 0;

    irq_ctrl #(.N_SRC(8), .BASE_ADDR(8'h10)) dut (
        .clk_ip   (clk_ip),
        .reset_ip (reset_ip),
        .src_ip   (src_ip),
        .addr_ip  (addr_ip),
        .data_ip  (data_ip),
        .wr_en_ip (wr_en_ip),
        .rd_en_ip (rd_en_ip),
        .data_op  (data_op),
        .sel_op   (sel_op),
        .irq_op   (irq_op)
    );

    always #10 clk_ip = ~clk_ip;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_sel;
        logic       exp_irq;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_ip);
    endtask

    task automatic chk_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        addr_ip = a;
        #1;
        chk(name, data_op, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        addr_ip  = a;
        data_ip  = d;
        wr_en_ip = 1'b1;
        @(negedge clk_ip);
        wr_en_ip = 1'b0;
        $display("write addr=%02h data=%02h", a, d);
    endtask

    task automatic vec_ack(input string name, input logic [7:0] exp);
        addr_ip  = 8'h12;
        rd_en_ip = 1'b1;
        #1;
        chk(name, data_op, exp);
        $display("vector read data=%02h", data_op);
        @(negedge clk_ip);
        rd_en_ip = 1'b0;
    endtask

    initial begin
        int hi;

        //          wr    rd    addr   wdata  exp    sel   irq
        tbl[0]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h13, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'h13, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h14, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h15, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h15, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h11, 8'hFF, 8'h00, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h11, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 8'h13, 8'h00, 8'h01, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'h13, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset state
        repeat (2) step();
        chk_reg("rst_ie", 8'h10, 8'h00);
        chk_reg("rst_ip", 8'h11, 8'h00);
        chk_reg("rst_ctrl", 8'h13, 8'h00);
        chk("rst_irq", {7'b0, irq_op}, 8'h00);
        reset_ip = 1'b0;
        step();

        // Register access table: outputs checked before the edge that commits the write
        for (int i = 0; i < 17; i++) begin
            wr_en_ip = tbl[i].wr;
            rd_en_ip = tbl[i].rd;
            addr_ip  = tbl[i].addr;
            data_ip  = tbl[i].wdata;
            #1;
            $display("vec %0d wr=%0b rd=%0b addr=%02h wdata=%02h data_op=%02h sel=%0b irq=%0b",
                     i, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, data_op, sel_op, irq_op);
            chk("tbl_data", data_op, tbl[i].exp_data);
            chk("tbl_sel", {7'b0, sel_op}, {7'b0, tbl[i].exp_sel});
            chk("tbl_irq", {7'b0, irq_op}, {7'b0, tbl[i].exp_irq});
            step();
            wr_en_ip = 1'b0;
            rd_en_ip = 1'b0;
        end

        // Single source latency
        bus_write(8'h10, 8'h08);
        bus_write(8'h13, 8'h01);
        src_ip[3] = 1'b1;
        step();
        step();
        chk_reg("lat_ip_k1", 8'h11, 8'h00);
        step();
        chk_reg("lat_ip_k2", 8'h11, 8'h08);
        chk("lat_irq_k2", {7'b0, irq_op}, 8'h00);
        step();
        chk("lat_irq_k3", {7'b0, irq_op}, 8'h01);
        chk_reg("lat_vec_peek", 8'h12, 8'h83);
        chk_reg("lat_ip_kept", 8'h11, 8'h08);
        vec_ack("lat_vec", 8'h83);
        chk_reg("lat_ip_acked", 8'h11, 8'h00);
        chk("lat_irq_acked", {7'b0, irq_op}, 8'h00);
        chk_reg("lat_ctrl_act", 8'h13, 8'h03);
        bus_write(8'h14, 8'h00);
        chk_reg("lat_ctrl_eoi", 8'h13, 8'h01);
        step();
        chk("lat_irq_eoi", {7'b0, irq_op}, 8'h00);
        src_ip[3] = 1'b0;

        // Priority and re-request
        bus_write(8'h10, 8'hFF);
        src_ip = 8'h22;
        repeat (4) step();
        chk("pri_irq", {7'b0, irq_op}, 8'h01);
        vec_ack("pri_vec1", 8'h81);
        chk_reg("pri_ip", 8'h11, 8'h20);
        bus_write(8'h14, 8'h00);
        step();
        chk("pri_rereq", {7'b0, irq_op}, 8'h01);
        vec_ack("pri_vec2", 8'h85);
        bus_write(8'h14, 8'h00);
        chk_reg("pri_ip_done", 8'h11, 8'h00);
        src_ip = 8'h00;

        // Masking
        bus_write(8'h10, 8'h00);
        src_ip[2] = 1'b1;
        repeat (4) step();
        chk_reg("mask_ip", 8'h11, 8'h04);
        chk("mask_irq", {7'b0, irq_op}, 8'h00);
        chk_reg("mask_vec", 8'h12, 8'h00);
        bus_write(8'h10, 8'h04);
        chk("mask_irq_1", {7'b0, irq_op}, 8'h00);
        step();
        chk("mask_irq_2", {7'b0, irq_op}, 8'h01);
        bus_write(8'h11, 8'h04);
        chk_reg("mask_w1c", 8'h11, 8'h00);
        step();
        chk("mask_drop", {7'b0, irq_op}, 8'h00);
        chk_reg("mask_ctrl", 8'h13, 8'h01);
        src_ip = 8'h00;

        // Set/clear collision on IP[0]
        bus_write(8'h10, 8'h00);
        src_ip[0] = 1'b1;
        step();
        step();
        bus_write(8'h11, 8'h01);
        chk_reg("coll_set_wins", 8'h11, 8'h01);
        bus_write(8'h11, 8'h01);
        chk_reg("coll_clear", 8'h11, 8'h00);
        src_ip = 8'h00;

        // Level source: one service per rising edge
        bus_write(8'h10, 8'h10);
        src_ip[4] = 1'b1;
        repeat (4) step();
        chk("lvl_irq", {7'b0, irq_op}, 8'h01);
        vec_ack("lvl_vec", 8'h84);
        bus_write(8'h14, 8'h00);
        hi = 0;
        repeat (44) begin
            step();
            if (irq_op) hi++;
        end
        chk("lvl_no_rereq", 8'(hi), 8'h00);
        chk_reg("lvl_ip", 8'h11, 8'h00);
        src_ip[4] = 1'b0;
        repeat (2) step();
        src_ip[4] = 1'b1;
        repeat (4) step();
        chk("lvl_irq2", {7'b0, irq_op}, 8'h01);
        vec_ack("lvl_vec2", 8'h84);
        bus_write(8'h14, 8'h00);
        src_ip = 8'h00;

        // Reset mid-service with IP=05 and ACTIVE
        bus_write(8'h10, 8'h01);
        src_ip = 8'h05;
        repeat (4) step();
        vec_ack("rst2_vec", 8'h80);
        src_ip[0] = 1'b0;
        repeat (2) step();
        src_ip[0] = 1'b1;
        repeat (3) step();
        chk_reg("rst2_ip_pre", 8'h11, 8'h05);
        chk_reg("rst2_ctrl_pre", 8'h13, 8'h03);
        reset_ip = 1'b1;
        src_ip   = 8'h00;
        chk_reg("rst2_ie", 8'h10, 8'h00);
        chk_reg("rst2_ip", 8'h11, 8'h00);
        chk_reg("rst2_ctrl", 8'h13, 8'h00);
        chk("rst2_irq", {7'b0, irq_op}, 8'h00);
        step();
        reset_ip = 1'b0;
        hi = 0;
        repeat (20) begin
            step();
            if (irq_op) hi++;
        end
        chk("rst2_idle", 8'(hi), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
